// File: rtl/latch_ctrl_pkg.sv
// latch_ctrl_pkg: shared state encoding and default parameters for the latch bank write controller
package latch_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, OPEN = 2'd2, HOLD = 2'd3} state_t;
    localparam int NREQ_DEF      = 4;
    localparam int DW_DEF        = 8;
    localparam int NWORDS_DEF    = 4;
    localparam int AW_DEF        = 2;
    localparam int EN_CYCLES_DEF = 1;
endpackage

// File: rtl/latch_bank_ctrl_arb.sv
// rr_arbiter: round-robin pick among NREQ requests, search starts one past the last grant
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [IW-1:0]   gnt,
    output logic            valid
);
    logic [IW-1:0] ptr;
    // scan from the far end so the candidate closest to ptr is written last and wins
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                gnt   = IW'((int'(ptr) + k) % NREQ);
                valid = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr <= '0;
        else if (en && valid)
            ptr <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;
    end
endmodule

// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl: sequences data/enable of a D-latch bank so data is stable around every enable window
module latch_bank_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int DW        = DW_DEF,
    parameter int NWORDS    = NWORDS_DEF,
    parameter int AW        = AW_DEF,
    parameter int EN_CYCLES = EN_CYCLES_DEF,
    parameter int GW        = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*AW-1:0] wr_addr,
    input  logic [NREQ*DW-1:0] wr_data,
    output logic [NREQ-1:0]  ack,
    output logic             err,
    output logic             busy,
    output logic [GW-1:0]    grant_id,
    output logic [DW-1:0]    lat_d,
    output logic [NWORDS-1:0] lat_en
);
    state_t        state;
    logic [AW-1:0] cap_addr;
    logic [3:0]    cnt;
    logic [GW-1:0] win;
    logic          win_valid;
    logic          in_range;

    rr_arbiter #(.NREQ(NREQ), .IW(GW)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == IDLE),
        .req   (req),
        .gnt   (win),
        .valid (win_valid)
    );

    assign in_range = 32'(cap_addr) < NWORDS;

    // lat_d doubles as the captured data register, so it is only loaded on grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat_en   <= '0;
            lat_d    <= '0;
            ack      <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            grant_id <= '0;
            cap_addr <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (win_valid) begin
                    state    <= SETUP;
                    busy     <= 1'b1;
                    grant_id <= win;
                    cap_addr <= wr_addr[int'(win)*AW +: AW];
                    lat_d    <= wr_data[int'(win)*DW +: DW];
                end
                SETUP: begin
                    state  <= OPEN;
                    cnt    <= 4'(EN_CYCLES);
                    lat_en <= in_range ? NWORDS'(1) << cap_addr : '0;
                end
                OPEN: if (cnt == 4'd1) begin
                    state  <= HOLD;
                    lat_en <= '0;
                    ack    <= NREQ'(1) << grant_id;
                    err    <= !in_range;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                HOLD: begin
                    state <= IDLE;
                    ack   <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_latch_bank_ctrl.sv
// tb_latch_bank_ctrl: directed vectors against three controller configurations sharing one stimulus bus
module tb_latch_bank_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    logic [3:0] ack1, ack3, ack4;
    logic       err1, err3, err4;
    logic       busy1, busy3, busy4;
    logic [1:0] gid1, gid3, gid4;
    logic [7:0] lat_d1, lat_d3, lat_d4;
    logic [3:0] lat_en1, lat_en4;
    logic [2:0] lat_en3;

    logic [7:0] mem [4];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    latch_bank_ctrl dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
        .ack(ack1), .err(err1), .busy(busy1), .grant_id(gid1), .lat_d(lat_d1), .lat_en(lat_en1)
    );
    latch_bank_ctrl #(.NWORDS(3), .AW(2), .EN_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
        .ack(ack3), .err(err3), .busy(busy3), .grant_id(gid3), .lat_d(lat_d3), .lat_en(lat_en3)
    );
    latch_bank_ctrl #(.EN_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
        .ack(ack4), .err(err4), .busy(busy4), .grant_id(gid4), .lat_d(lat_d4), .lat_en(lat_en4)
    );

    // behavioural transparent latches driven by dut1
    always @(lat_en1, lat_d1)
        for (int i = 0; i < 4; i++)
            if (lat_en1[i]) mem[i] = lat_d1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] a, input logic [7:0] d);
        wr_addr[i*2 +: 2] = a;
        wr_data[i*8 +: 8] = d;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req   = '0;
        step;
        step;
        rst_n = 1'b1;
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        int cnt, ack_cyc, multi;
        logic found, any_ack;
        rst_n = 1'b0; req = '0; wr_addr = '0; wr_data = '0;
        step;
        check("rst_busy", busy1, 0);
        check("rst_ack", ack1, 0);
        check("rst_err", err1, 0);
        check("rst_lat_en", lat_en1, 0);
        check("rst_lat_d", lat_d1, 0);
        check("rst_gid", gid1, 0);
        rst_n = 1'b1;
        step;

        set_req(2, 2'd1, 8'hA5);
        req = 4'b0100;
        step;
        check("w1_setup_busy", busy1, 1);
        check("w1_setup_d", lat_d1, 8'hA5);
        check("w1_setup_en", lat_en1, 0);
        check("w1_setup_ack", ack1, 0);
        step;
        check("w1_open_en", lat_en1, 4'b0010);
        check("w1_open_d", lat_d1, 8'hA5);
        step;
        check("w1_hold_en", lat_en1, 0);
        check("w1_hold_ack", ack1, 4'b0100);
        check("w1_hold_err", err1, 0);
        check("w1_hold_busy", busy1, 1);
        check("w1_hold_gid", gid1, 2);
        req = '0;
        step;
        check("w1_idle_busy", busy1, 0);
        check("w1_idle_ack", ack1, 0);
        check("w1_idle_d", lat_d1, 8'hA5);
        check("w1_latch", mem[1], 8'hA5);

        do_reset;
        for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'h10 + 8'(i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                step;
                found = |ack1;
            end
            if (!found) begin
                check("rr_timeout", 0, 1);
                break;
            end
            check("rr_gid", gid1, order[k]);
            check("rr_ack", ack1, 4'(1) << order[k]);
            req[gid1] = 1'b0;
            if (k == 0) begin
                step;
                req[0] = 1'b1;
            end
        end
        req = '0;
        for (int i = 0; i < 4; i++) check("rr_latch", mem[i], 8'h10 + 8'(i));

        do_reset;
        set_req(0, 2'd3, 8'h11);
        req = 4'b0001;
        step;
        step;
        wr_data[7:0] = 8'h22;
        check("dc_open_d", lat_d1, 8'h11);
        check("dc_open_en", lat_en1, 4'b1000);
        step;
        check("dc_hold_d", lat_d1, 8'h11);
        check("dc_hold_ack", ack1, 4'b0001);
        req = '0;
        step;
        check("dc_latch", mem[3], 8'h11);

        do_reset;
        set_req(1, 2'd3, 8'h5A);
        req = 4'b0010;
        for (int c = 1; c <= 6; c++) begin
            step;
            check("oor_en", lat_en3, 0);
            if (c == 5) begin
                check("oor_ack", ack3, 4'b0010);
                check("oor_err", err3, 1);
                req = '0;
            end
        end

        do_reset;
        set_req(1, 2'd2, 8'h77);
        req = 4'b0010;
        step;
        step;
        check("mr_open_en", lat_en3, 3'b100);
        step;
        rst_n = 1'b0;
        req = '0;
        step;
        check("mr_en", lat_en3, 0);
        check("mr_d", lat_d3, 0);
        check("mr_ack", ack3, 0);
        check("mr_err", err3, 0);
        check("mr_busy", busy3, 0);
        check("mr_gid", gid3, 0);
        rst_n = 1'b1;
        any_ack = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step;
            any_ack |= |ack3;
        end
        check("mr_no_ack", any_ack, 0);
        set_req(2, 2'd0, 8'h01);
        req = 4'b0110;
        step;
        check("mr_ptr", gid3, 1);
        req = '0;

        do_reset;
        set_req(3, 2'd2, 8'h3C);
        req = 4'b1000;
        cnt = 0; ack_cyc = -1; multi = 0;
        for (int c = 1; c <= 9; c++) begin
            step;
            if (lat_en4 != 0) cnt++;
            if ($countones(lat_en4) > 1) multi++;
            if (c == 2) check("st_en_val", lat_en4, 4'b0100);
            if (ack4 != 0 && ack_cyc < 0) begin
                ack_cyc = c;
                req = '0;
            end
        end
        check("st_en_cycles", cnt, 4);
        check("st_ack_cycle", ack_cyc, 6);
        check("st_onehot", multi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/latch_bank_ctrl.md
# latch_bank_ctrl

Write controller for a bank of level-sensitive D latches built from the team's `dlatch_udp` primitive. Up to NREQ requesters issue word writes. A round-robin arbiter picks one request at a time, and a small FSM sequences the latch data and enable lines so that data is stable before, during and after each enable window. This guarantees race-free latch capture. The block sits between bus-side requesters and the latch register bank.

## Interface
- NREQ, 4: number of requesters (2..8)
- DW, 8: data width per latch word
- NWORDS, 4: latch words in bank
- AW, 2: address width, clog2(NWORDS)
- EN_CYCLES, 1: cycles lat_en is held high (1..15)

Ports:
- clk  in  1  single clock, rising-edge
- rst_n  in  1  reset, synchronous, active-low
- req  in  NREQ  per-requester write request, level
- wr_addr  in  NREQ*AW  flattened addresses, requester i at [i*AW +: AW]
- wr_data  in  NREQ*DW  flattened data, requester i at [i*DW +: DW]
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse with ack when address ≥ NWORDS
- busy  out  1  high in every state except IDLE
- grant_id  out  clog2(NREQ)  index of the current/last granted requester
- lat_d  out  DW  data to all latch D inputs
- lat_en  out  NWORDS  one-hot latch enables

## Operation
- FSM states: IDLE, SETUP, OPEN, HOLD.
- IDLE: if any req is high, arbitrate and go to SETUP. At the same edge, register grant_id and capture the winner's addr and data. Otherwise stay in IDLE.
- SETUP: lat_d = captured data; lat_en = 0. Next state is OPEN; load enable counter with EN_CYCLES.
- OPEN: lat_en = onehot(captured addr); decrement counter. Go to HOLD when the counter reaches 1.
- HOLD: lat_en = 0; lat_d stays unchanged. ack[grant_id] = 1 and err is valid. Next state is IDLE.
- Arbitration is round-robin. The search starts at (last grant + 1) mod NREQ. After reset the pointer is 0, so req[0] has highest priority. The pointer updates only on grant.
- Captured addr/data are the only values used. Changes on wr_addr/wr_data or req after grant are ignored.
- Requester protocol: hold req until ack, then drop req in the cycle after ack. If req is still high when the FSM returns to IDLE, it is treated as a new write.
- Out-of-range address: the full sequence still runs, lat_en stays 0 throughout, and err pulses with ack.
- lat_d is held after HOLD until the next SETUP; it is not cleared.
- No two lat_en bits are ever high simultaneously.

## Timing
- Reset (rst_n low at an edge): state = IDLE, lat_en = 0, lat_d = 0, ack = 0, err = 0, busy = 0, grant_id = 0, pointer = 0.
- Reset mid-transaction: everything returns to reset values at that edge, lat_en drops immediately registered, and no ack is issued.
- All outputs are registered; none is combinational from inputs.
- req sampled high in IDLE at edge t produces:
  - SETUP in t+1;
  - OPEN in t+2 .. t+1+EN_CYCLES;
  - HOLD with ack in t+2+EN_CYCLES;
  - IDLE in t+3+EN_CYCLES.
- Throughput is one write per 3+EN_CYCLES cycles.
- lat_d is stable for at least one cycle before the first lat_en-high cycle and at least one cycle after the last one.

## Structure
- Package latch_ctrl_pkg holds the state enum (IDLE=2'd0, SETUP=2'd1, OPEN=2'd2, HOLD=2'd3) and default parameter constants.
- Sub-module rr_arbiter (NREQ): inputs req, pointer, and an enable; outputs grant index and a valid flag. It contains the pointer register.
- The top level contains the FSM, capture registers, enable counter and one-hot decode.

## Test plan
- Single write: req[2]=1, addr=1, data=8'hA5, EN_CYCLES=1.
  - Expect lat_d=A5 from t+1; lat_en=4'b0010 only at t+2; ack[2] at t+3; busy high t+1..t+3.
- Round-robin: req=4'b1111 held, each bit dropped after its ack.
  - Expect grants in order 0,1,2,3. A re-raised req[0] is granted only after 3.
- Out of range: NWORDS=3 and addr=3.
  - Expect lat_en to stay 0 for the whole sequence, and err together with ack.
- Data change after grant: wr_data goes 8'h11 → 8'h22 during OPEN.
  - Expect lat_d to stay 11. A behavioural latch model captures 11.
- Reset mid-operation: rst_n=0 during OPEN with EN_CYCLES=3.
  - Expect all outputs 0 at the next edge, no ack, and pointer 0.
- Stretched enable: EN_CYCLES=4.
  - Expect lat_en high for exactly 4 cycles, ack 6 cycles after the request edge, and never more than one lat_en bit high.
